// File: rtl/bus_arbiter.sv
// Two-requester round-robin bus arbiter with address decode, slave timeout
// and a registered one-cycle response back to the granted requester.
module bus_arbiter #(
  parameter logic [31:0] rom_base_addr   = 32'h0000_0000,
  parameter logic [31:0] rom_top_addr    = 32'h0000_0080,
  parameter logic [31:0] uart_base_addr  = 32'h0100_0000,
  parameter logic [31:0] uart_top_addr   = 32'h0100_0004,
  parameter logic [31:0] clint_base_addr = 32'h0200_0000,
  parameter logic [31:0] clint_top_addr  = 32'h0200_C000,
  parameter logic [31:0] tim0_base_addr  = 32'h1000_0000,
  parameter logic [31:0] tim0_top_addr   = 32'h1010_0000,
  parameter logic [31:0] tim1_base_addr  = 32'h2000_0000,
  parameter logic [31:0] tim1_top_addr   = 32'h2010_0000,
  parameter logic [31:0] ram_base_addr   = 32'h8000_0000,
  parameter logic [31:0] ram_top_addr    = 32'h9000_0000,
  parameter int unsigned timeout_cycles  = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_error,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_error,
  output logic        s_valid,
  output logic [2:0]  s_sel,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SEL_W = 3;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(timeout_cycles - 1);
  localparam bit TMO_EN = (timeout_cycles != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               instr_q, instr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               any_valid;
  logic               grant_m1;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic [3:0]         req_wstrb;
  logic               hit;
  logic [SEL_W-1:0]   dec_sel;
  logic               tmo_hit;

  function automatic logic in_win(input logic [31:0] a, input logic [31:0] lo,
                                  input logic [31:0] hi);
    return (a >= lo) && (a < hi);
  endfunction

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    any_valid = m0_valid | m1_valid;
    grant_m1  = m1_valid & (~m0_valid | ~last_grant_q);
    req_addr  = grant_m1 ? m1_addr  : m0_addr;
    req_wdata = grant_m1 ? m1_wdata : m0_wdata;
    req_wstrb = grant_m1 ? m1_wstrb : m0_wstrb;
  end

  // Address map decode, first match in slave-select order.
  always_comb begin
    hit     = 1'b1;
    dec_sel = '0;
    if (in_win(req_addr, rom_base_addr, rom_top_addr))             dec_sel = SEL_W'(0);
    else if (in_win(req_addr, uart_base_addr, uart_top_addr))      dec_sel = SEL_W'(1);
    else if (in_win(req_addr, clint_base_addr, clint_top_addr))    dec_sel = SEL_W'(2);
    else if (in_win(req_addr, tim0_base_addr, tim0_top_addr))      dec_sel = SEL_W'(3);
    else if (in_win(req_addr, tim1_base_addr, tim1_top_addr))      dec_sel = SEL_W'(4);
    else if (in_win(req_addr, ram_base_addr, ram_top_addr))        dec_sel = SEL_W'(5);
    else hit = 1'b0;
  end

  assign tmo_hit = TMO_EN && (cnt_q == TMO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      instr_q      <= 1'b0;
      sel_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      instr_q      <= instr_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    instr_d      = instr_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          last_grant_d = grant_m1;
          instr_d      = ~grant_m1;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          wstrb_d      = req_wstrb;
          sel_d        = dec_sel;
          cnt_d        = '0;
          if (hit) begin
            state_d = ACCESS;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ACCESS: begin
        // A completing slave beats a timeout expiring in the same cycle.
        if (s_ready) begin
          rdata_d = (wstrb_q == 4'd0) ? s_rdata : 32'd0;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    s_valid  = 1'b0;
    s_sel    = '0;
    s_instr  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m0_rdata = '0;
    m0_error = 1'b0;
    m1_ready = 1'b0;
    m1_rdata = '0;
    m1_error = 1'b0;
    if (state_q == ACCESS) begin
      s_valid = 1'b1;
      s_sel   = sel_q;
      s_instr = instr_q;
      s_addr  = addr_q;
      s_wdata = wdata_q;
      s_wstrb = wstrb_q;
    end
    if (state_q == RESP) begin
      if (instr_q) begin
        m0_ready = 1'b1;
        m0_rdata = rdata_q;
        m0_error = err_q;
      end else begin
        m1_ready = 1'b1;
        m1_rdata = rdata_q;
        m1_error = err_q;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: transaction-level model predicts grant
// order, slave requests and response timing; monitors compare independently.
module tb_bus_arbiter;

  localparam int TMO   = 1024;
  localparam int NEVER = 5000;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready, m0_error, m1_error;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr;
  logic [2:0]  s_sel;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = 32'd0;

  bus_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_error(m0_error),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_error(m1_error),
    .s_valid(s_valid), .s_sel(s_sel), .s_instr(s_instr), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wait_c;
    logic [31:0] rdata;
  } req_t;

  typedef struct {
    bit          m;
    logic [31:0] rdata;
    bit          err;
    int          at;
  } rsp_t;

  typedef struct {
    logic [2:0]  sel;
    bit          instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wait_c;
    logic [31:0] rdata;
    int          act;
  } sx_t;

  rsp_t rq[$];
  sx_t  sq[$];
  int   total = 0;
  int   bad = 0;
  bit   lg = 1'b1;
  bit   mon_en = 1'b0;
  bit   abort_exp = 1'b0;

  logic [31:0] base_t [6] = '{32'h0000_0000, 32'h0100_0000, 32'h0200_0000,
                              32'h1000_0000, 32'h2000_0000, 32'h8000_0000};
  logic [31:0] top_t  [6] = '{32'h0000_0080, 32'h0100_0004, 32'h0200_C000,
                              32'h1010_0000, 32'h2010_0000, 32'h9000_0000};

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int dec(input logic [31:0] a);
    for (int i = 0; i < 6; i++)
      if (a >= base_t[i] && a < top_t[i]) return i;
    return -1;
  endfunction

  function automatic int act_len(input int wait_c);
    return (wait_c + 1 < TMO) ? wait_c + 1 : TMO;
  endfunction

  function automatic int lat(input req_t r);
    if (dec(r.addr) < 0) return 1;
    return 1 + act_len(r.wait_c);
  endfunction

  function automatic req_t mk(input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, input int wt, input logic [31:0] rd);
    req_t r;
    r.addr = a; r.wdata = wd; r.wstrb = ws; r.wait_c = wt; r.rdata = rd;
    return r;
  endfunction

  task automatic push_s(input bit m, input req_t r);
    sx_t s;
    int  d;
    d = dec(r.addr);
    if (d >= 0) begin
      s.sel = 3'(d); s.instr = !m; s.addr = r.addr; s.wdata = r.wdata;
      s.wstrb = r.wstrb; s.wait_c = r.wait_c; s.rdata = r.rdata;
      s.act = act_len(r.wait_c);
      sq.push_back(s);
    end
  endtask

  task automatic push_r(input bit m, input req_t r, input int at);
    rsp_t e;
    e.m = m;
    e.at = at;
    e.err = (dec(r.addr) < 0) || (r.wait_c >= TMO);
    e.rdata = (e.err || r.wstrb != 4'd0) ? 32'd0 : r.rdata;
    rq.push_back(e);
  endtask

  // Slave model: checks the forwarded request and answers after wait_c cycles.
  bit  in_txn = 1'b0;
  bit  cur_ok = 1'b0;
  sx_t cur;
  int  act_n = 0;
  always @(negedge clock) begin
    if (s_valid === 1'b1) begin
      if (!in_txn) begin
        in_txn = 1'b1;
        act_n = 0;
        if (sq.size() == 0) begin
          total++; bad++; cur_ok = 1'b0;
          $display("FAIL s_valid_unexpected: got s_valid=1 addr %h want no slave access", s_addr);
        end else begin
          cur = sq.pop_front();
          cur_ok = 1'b1;
        end
      end
      if (cur_ok)
        chk("s_fields", {s_sel, s_instr, s_addr, s_wdata, s_wstrb},
            {cur.sel, cur.instr, cur.addr, cur.wdata, cur.wstrb});
      act_n++;
      if (cur_ok && act_n - 1 == cur.wait_c) begin
        s_ready = 1'b1;
        s_rdata = cur.rdata;
      end else begin
        s_ready = 1'b0;
        s_rdata = $urandom;
      end
    end else begin
      if (in_txn) begin
        if (cur_ok && !abort_exp) chk("s_valid_cycles", 80'(act_n), 80'(cur.act));
        in_txn = 1'b0;
        abort_exp = 1'b0;
      end
      s_ready = 1'b0;
      s_rdata = $urandom;
    end
  end

  // Response monitor: pops the scoreboard whenever a ready pulse appears.
  rsp_t        e;
  logic [31:0] mrd;
  logic        merr;
  always @(negedge clock) begin
    if (mon_en) begin
      if (!m0_ready) chk("m0_quiet", {m0_rdata, m0_error}, 80'd0);
      if (!m1_ready) chk("m1_quiet", {m1_rdata, m1_error}, 80'd0);
      if (m0_ready || m1_ready) begin
        chk("one_ready", 80'(m0_ready & m1_ready), 80'd0);
        mrd  = m1_ready ? m1_rdata : m0_rdata;
        merr = m1_ready ? m1_error : m0_error;
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: got m0_ready=%0b m1_ready=%0b want none", m0_ready, m1_ready);
        end else begin
          e = rq.pop_front();
          chk("rsp_master", 80'(m1_ready), 80'(e.m));
          chk("rsp_rdata", 80'(mrd), 80'(e.rdata));
          chk("rsp_error", 80'(merr), 80'(e.err));
          chk("rsp_cycle", 80'(cyc), 80'(e.at));
        end
      end
    end
  end

  task automatic round(input bit v0, input req_t r0, input bit v1, input req_t r1);
    bit   first;
    int   t;
    int   budget;
    req_t rf, rs;
    if (!v0 && !v1) return;
    @(negedge clock);
    first = (v0 && v1) ? !lg : v1;
    if (first) begin rf = r1; rs = r0; end else begin rf = r0; rs = r1; end
    t = cyc + lat(rf);
    push_r(first, rf, t);
    push_s(first, rf);
    if (v0 && v1) begin
      t = t + 1 + lat(rs);
      push_r(!first, rs, t);
      push_s(!first, rs);
      lg = !first;
    end else begin
      lg = first;
    end
    m0_valid = v0;
    m0_addr  = v0 ? r0.addr  : $urandom;
    m0_wdata = v0 ? r0.wdata : $urandom;
    m0_wstrb = v0 ? r0.wstrb : 4'($urandom);
    m1_valid = v1;
    m1_addr  = v1 ? r1.addr  : $urandom;
    m1_wdata = v1 ? r1.wdata : $urandom;
    m1_wstrb = v1 ? r1.wstrb : 4'($urandom);
    budget = 2 * (TMO + 8);
    while ((m0_valid || m1_valid) && budget > 0) begin
      @(negedge clock);
      budget--;
      if (m0_ready) m0_valid = 1'b0;
      if (m1_ready) m1_valid = 1'b0;
    end
    if (m0_valid || m1_valid) begin
      total++; bad++;
      $display("FAIL round_hang: got valid still pending after %0d cycles want ready", 2 * (TMO + 8));
      m0_valid = 1'b0;
      m1_valid = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int w, m;
    logic [31:0] b, tp;
    w = $urandom_range(0, 6);
    m = $urandom_range(0, 4);
    if (w == 6) return $urandom;
    b = base_t[w];
    tp = top_t[w];
    case (m)
      0: return b;
      1: return tp - 32'd4;
      2: return tp;
      3: return b - 32'd4;
      default: return b + (($urandom % (tp - b)) & ~32'h3);
    endcase
  endfunction

  function automatic req_t rand_req();
    logic [3:0] ws;
    ws = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
    return mk(rand_addr(), $urandom, ws, $urandom_range(0, 4), $urandom);
  endfunction

  initial begin
    req_t r, na;
    bit   v0, v1;
    na = mk(32'd0, 32'd0, 4'd0, 0, 32'd0);
    reset = 1'b1;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    repeat (2) @(negedge clock);
    chk("reset_slave_side", {s_valid, s_sel, s_instr, s_addr, s_wdata, s_wstrb}, 80'd0);
    chk("reset_m0", {m0_ready, m0_rdata, m0_error}, 80'd0);
    chk("reset_m1", {m1_ready, m1_rdata, m1_error}, 80'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    lg = 1'b1;

    // Contention straight out of reset: m0, m1, m0, m1.
    round(1, mk(32'h10, 32'h0, 4'h0, 0, 32'h1111_0000), 1, mk(32'h8000_0020, 32'h0, 4'h0, 0, 32'h2222_0000));
    round(1, mk(32'h14, 32'h0, 4'h0, 0, 32'h3333_0000), 1, mk(32'h8000_0024, 32'hAB, 4'hF, 0, 32'h4444_0000));

    round(0, na, 1, mk(32'h8000_0010, 32'h0, 4'h0, 0, 32'hDEAD_BEEF));

    round(0, na, 1, mk(32'h0100_0004, 32'h55, 4'hF, 0, 32'h1));
    round(0, na, 1, mk(32'h0100_0000, 32'h55, 4'hF, 0, 32'h2));
    round(0, na, 1, mk(32'h8FFF_FFFC, 32'h0, 4'h0, 1, 32'h3));
    round(0, na, 1, mk(32'h9000_0000, 32'h0, 4'h0, 0, 32'h4));
    round(1, mk(32'h7C, 32'h0, 4'h0, 2, 32'h5), 0, na);
    round(1, mk(32'h80, 32'h0, 4'h0, 0, 32'h6), 0, na);

    round(0, na, 1, mk(32'h0200_0000, 32'h0, 4'h0, NEVER, 32'h7));
    round(0, na, 1, mk(32'h0200_0000, 32'h0, 4'h0, TMO - 1, 32'hCAFE_F00D));
    round(0, na, 1, mk(32'h0200_0000, 32'h0, 4'h0, TMO - 2, 32'h0BAD_CAFE));

    round(0, na, 1, mk(32'h1000_0008, 32'h1234_5678, 4'b0011, 5, 32'hFFFF_FFFF));

    // Reset in the third ACCESS cycle discards the fetch; m0 then wins again.
    r = mk(32'h40, 32'h0, 4'h0, NEVER, 32'h9);
    @(negedge clock);
    push_s(1'b0, r);
    m0_valid = 1'b1; m0_addr = r.addr; m0_wdata = r.wdata; m0_wstrb = r.wstrb;
    repeat (3) @(negedge clock);
    chk("s_valid_before_reset", 80'(s_valid), 80'd1);
    reset = 1'b1;
    abort_exp = 1'b1;
    m0_valid = 1'b0;
    @(negedge clock);
    chk("s_valid_after_reset", 80'(s_valid), 80'd0);
    chk("m0_ready_after_reset", 80'(m0_ready), 80'd0);
    reset = 1'b0;
    lg = 1'b1;
    repeat (3) @(negedge clock);
    round(1, mk(32'h8000_0100, 32'h0, 4'h0, 0, 32'hA0A0_A0A0), 1, mk(32'h2000_0000, 32'h0, 4'h0, 0, 32'hB0B0_B0B0));

    for (int i = 0; i < 150; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      round(v0, rand_req(), v1, rand_req());
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (4) @(negedge clock);
    chk("rsp_queue_drained", 80'(rq.size()), 80'd0);
    chk("slave_queue_drained", 80'(sq.size()), 80'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion by 2ms want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
